// File: rtl/alu_muldiv_unit.sv
// Registered EX-stage ALU: decodes ALUOp/func into a one-cycle result and runs
// iterative shift-add multiply / restoring divide into the HI/LO registers.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SH_W-1:0]  shamt,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_take,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   aOrig_q, aOrig_d;
    logic               isDiv_q, isDiv_d;
    logic               negMain_q, negMain_d;
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic               valid_q, valid_d;
    logic               zero_q, zero_d;
    logic               branch_q, branch_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   aluRes;
    logic               aluBranch;
    logic               startMul;
    logic               startDiv;
    logic               signedOp;

    always_comb begin : decode
        aluRes    = a + b;
        aluBranch = 1'b0;
        startMul  = 1'b0;
        startDiv  = 1'b0;
        signedOp  = 1'b0;
        case (alu_op)
            3'b001: aluRes = a & b;
            3'b010: aluRes = a | b;
            3'b011: begin
                aluRes    = a - b;
                aluBranch = (a == b);
            end
            3'b100: begin
                aluRes    = a - b;
                aluBranch = (a != b);
            end
            3'b101: begin
                case (func)
                    F_ADD:   aluRes = a + b;
                    F_SUB:   aluRes = a - b;
                    F_SLL:   aluRes = b << shamt;
                    F_SRL:   aluRes = b >> shamt;
                    F_AND:   aluRes = a & b;
                    F_OR:    aluRes = a | b;
                    F_SLT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_MFHI:  aluRes = hi_q;
                    F_MFLO:  aluRes = lo_q;
                    F_MULT:  begin startMul = 1'b1; signedOp = 1'b1; end
                    F_MULTU: startMul = 1'b1;
                    F_DIV:   begin startDiv = 1'b1; signedOp = 1'b1; end
                    F_DIVU:  startDiv = 1'b1;
                    default: aluRes = a + b;
                endcase
            end
            default: aluRes = a + b;
        endcase
    end

    // Both engines iterate on magnitudes; signs are reapplied once in FIX.
    logic [WIDTH-1:0] absA, absB;
    assign absA = (signedOp && a[WIDTH-1]) ? -a : a;
    assign absB = (signedOp && b[WIDTH-1]) ? -b : b;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

    // acc holds {partial remainder, dividend bits still to consume / quotient bits}.
    logic [WIDTH:0]     divShift, divDiff;
    logic [2*WIDTH-1:0] divNext;
    assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB_q};
    assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quo, rem, fixHi, fixLo;
    assign prodFix = negMain_q ? -acc_q : acc_q;
    assign quo     = acc_q[WIDTH-1:0];
    assign rem     = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin : fixup
        fixHi = prodFix[2*WIDTH-1:WIDTH];
        fixLo = prodFix[WIDTH-1:0];
        if (isDiv_q) begin
            fixLo = divZero_q ? {WIDTH{1'b1}} : (negMain_q ? -quo : quo);
            fixHi = divZero_q ? aOrig_q       : (negRem_q  ? -rem : rem);
        end
    end

    always_comb begin : nextState
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        aOrig_d   = aOrig_q;
        isDiv_d   = isDiv_q;
        negMain_d = negMain_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (startMul || startDiv) begin
                        state_d   = startMul ? S_MUL : S_DIV;
                        cnt_d     = '0;
                        acc_d     = {{WIDTH{1'b0}}, absA};
                        opB_d     = absB;
                        aOrig_d   = a;
                        isDiv_d   = startDiv;
                        negMain_d = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                        negRem_d  = signedOp && a[WIDTH-1];
                        divZero_d = (b == '0);
                    end else begin
                        valid_d  = 1'b1;
                        result_d = aluRes;
                        zero_d   = (aluRes == '0);
                        branch_d = aluBranch;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_DIV) ? divNext : mulNext;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d  = S_IDLE;
                hi_d     = fixHi;
                lo_d     = fixLo;
                result_d = fixLo;
                zero_d   = (fixLo == '0);
                branch_d = 1'b0;
                valid_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            aOrig_q   <= '0;
            isDiv_q   <= 1'b0;
            negMain_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            aOrig_q   <= aOrig_d;
            isDiv_q   <= isDiv_d;
            negMain_q <= negMain_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign valid_out   = valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign branch_take = branch_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed corner cases plus random ops checked
// against a plain-arithmetic model of the ALU and HI/LO registers.
module tb_alu_muldiv_unit;
    localparam int W  = 32;
    localparam int SW = 5;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          in_ready;
    logic [2:0]    alu_op;
    logic [5:0]    func;
    logic [W-1:0]  a, b;
    logic [SW-1:0] shamt;
    logic          valid_out;
    logic [W-1:0]  result;
    logic          zero;
    logic          branch_take;
    logic [W-1:0]  hi, lo;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] hiM, loM;
    logic [W-1:0] lastResult;

    alu_muldiv_unit #(.WIDTH(W), .SH_W(SW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .alu_op(alu_op), .func(func), .a(a), .b(b), .shamt(shamt),
        .valid_out(valid_out), .result(result), .zero(zero),
        .branch_take(branch_take), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Architectural behaviour with 64-bit arithmetic; updates hiM/loM for mul/div.
    task automatic refModel(input logic [2:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [SW-1:0] sh,
                            output logic [W-1:0] res, output logic br, output bit multi);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        res = av + bv;
        br = 1'b0;
        multi = 1'b0;
        case (op)
            3'b001: res = av & bv;
            3'b010: res = av | bv;
            3'b011: begin res = av - bv; br = (av == bv); end
            3'b100: begin res = av - bv; br = (av != bv); end
            3'b101: begin
                case (fn)
                    F_SUB:  res = av - bv;
                    F_SLL:  res = bv << sh;
                    F_SRL:  res = bv >> sh;
                    F_AND:  res = av & bv;
                    F_OR:   res = av | bv;
                    F_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
                    F_MFHI: res = hiM;
                    F_MFLO: res = loM;
                    F_MULT, F_MULTU: begin
                        p = (fn == F_MULT) ? 64'(sa * sb) : ua * ub;
                        hiM = p[63:32];
                        loM = p[31:0];
                        res = loM;
                        multi = 1'b1;
                    end
                    F_DIV, F_DIVU: begin
                        if (bv == 0) begin
                            loM = '1;
                            hiM = av;
                        end else if (fn == F_DIV) begin
                            p = 64'(sa / sb);
                            loM = p[31:0];
                            p = 64'(sa % sb);
                            hiM = p[31:0];
                        end else begin
                            p = ua / ub;
                            loM = p[31:0];
                            p = ua % ub;
                            hiM = p[31:0];
                        end
                        res = loM;
                        multi = 1'b1;
                    end
                    default: res = av + bv;
                endcase
            end
            default: res = av + bv;
        endcase
    endtask

    // Issues one op (waiting for in_ready), then waits for its result and checks it.
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic [SW-1:0] sh);
        logic [W-1:0] expRes;
        logic         expBr;
        bit           multi;
        int           n;
        refModel(op, fn, av, bv, sh, expRes, expBr, multi);
        alu_op = op; func = fn; a = av; b = bv; shamt = sh; valid_in = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready", in_ready, 1);
        @(posedge clk);
        #1 valid_in = 1'b0;
        if (multi) begin
            n = 0;
            while (!valid_out && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            checkOutput("latency", n, W + 1);
        end else begin
            checkOutput("validOut", valid_out, 1);
        end
        checkOutput("result", result, expRes);
        checkOutput("zero", zero, (expRes == 0));
        checkOutput("branch", branch_take, expBr);
        checkOutput("hi", hi, hiM);
        checkOutput("lo", lo, loM);
        lastResult = result;
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0]   sweepFn  [8] = '{F_ADD, F_SUB, F_SLL, F_SRL, F_AND, F_OR, F_SLT, 6'h3F};
    logic [W-1:0] sweepExp [8] = '{32'hFF, 32'hE1, 32'hF0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'hFF};
    logic [5:0]   fnList   [13] = '{F_ADD, F_SUB, F_SLL, F_SRL, F_AND, F_OR, F_SLT, F_MFHI,
                                    F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin
        logic [W-1:0] expRes;
        logic         expBr;
        bit           multi;
        int           n;
        bit           early;
        logic [2:0]   rop;
        logic [5:0]   rfn;

        rst = 1'b1; valid_in = 1'b0; alu_op = '0; func = '0; a = '0; b = '0; shamt = '0;
        hiM = '0; loM = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", valid_out, 0);
        checkOutput("rstReady", in_ready, 1);
        checkOutput("rstResult", result, 0);
        checkOutput("rstZero", zero, 0);
        checkOutput("rstHiLo", {hi, lo}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b101, sweepFn[i], 32'hF0, 32'h0F, 5'd4);
            checkOutput("sweep", lastResult, sweepExp[i]);
        end

        applyStimulus(3'b011, 6'd0, 32'd9, 32'd9, 5'd0);
        checkOutput("beqTake", branch_take, 1);
        checkOutput("beqZero", zero, 1);
        applyStimulus(3'b100, 6'd0, 32'd9, 32'd3, 5'd0);
        checkOutput("bneResult", lastResult, 6);
        checkOutput("bneTake", branch_take, 1);

        applyStimulus(3'b101, F_MULT, -32'sd3, 32'd7, 5'd0);
        checkOutput("multHiLo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus(3'b101, F_MFHI, 32'd0, 32'd0, 5'd0);
        checkOutput("mfhiAfterMult", lastResult, 32'hFFFF_FFFF);
        applyStimulus(3'b101, F_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
        checkOutput("multuHiLo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        applyStimulus(3'b101, F_DIV, -32'sd7, 32'd2, 5'd0);
        checkOutput("divHiLo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(3'b101, F_DIVU, 32'd7, 32'd0, 5'd0);
        checkOutput("divByZero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        applyStimulus(3'b101, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        checkOutput("divOverflow", {hi, lo}, 64'h0000_0000_8000_0000);
        applyStimulus(3'b101, F_MFLO, 32'd0, 32'd0, 5'd0);
        checkOutput("mfloAfterDiv", lastResult, 32'h8000_0000);

        // ADD held on the bus while a DIV runs must wait for in_ready.
        refModel(3'b101, F_DIV, 32'd100, 32'd7, 5'd0, expRes, expBr, multi);
        alu_op = 3'b101; func = F_DIV; a = 32'd100; b = 32'd7; valid_in = 1'b1;
        checkOutput("hsReady", in_ready, 1);
        @(posedge clk);
        #1 func = F_ADD; a = 32'd5; b = 32'd7;
        n = 0;
        early = 1'b0;
        while (!valid_out && n < 200) begin
            if (in_ready) early = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("hsStall", early, 0);
        checkOutput("hsLatency", n, W + 1);
        checkOutput("hsDivLo", lo, 32'd14);
        checkOutput("hsDivHi", hi, 32'd2);
        checkOutput("hsReadyBack", in_ready, 1);
        @(posedge clk);
        #1 valid_in = 1'b0;
        checkOutput("hsAddValid", valid_out, 1);
        checkOutput("hsAddResult", result, 32'd12);
        @(posedge clk);
        #1;
        checkOutput("hsNoExtraPulse", valid_out, 0);

        // Reset in the middle of a DIV discards it and clears everything.
        alu_op = 3'b101; func = F_DIV; a = -32'sd7; b = 32'd2; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstValid", valid_out, 0);
        checkOutput("midRstReady", in_ready, 1);
        checkOutput("midRstResult", result, 0);
        checkOutput("midRstFlags", {zero, branch_take}, 0);
        checkOutput("midRstHiLo", {hi, lo}, 0);
        @(negedge clk) rst = 1'b0;
        hiM = '0;
        loM = '0;
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 6'd0, 32'd5, 32'd7, 5'd0);
        checkOutput("postRstAdd", lastResult, 12);

        for (int i = 0; i < 150; i++) begin
            rop = ($urandom_range(0, 7) < 4) ? 3'b101 : 3'($urandom_range(0, 7));
            rfn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 12)];
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                checkOutput("gapQuiet", valid_out, 0);
            end
            applyStimulus(rop, rfn, pickOperand(), pickOperand(), 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
